store_align_unit: RTL and testbench

STORE_ALIGN_UNIT -- requirements
Module: store_align_unit

---
 rtl/store_align_unit.sv | 153 +++++++++++++++
 tb/tb_store_align_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_align_unit.sv
// Store alignment unit: turns a byte/half/word store at any byte address into
// one or two word-aligned, lane-positioned write beats toward data memory.
// Misaligned stores that cross a word boundary are either split into two
// beats or rejected with an error pulse, selected by MISALIGN_SPLIT.
module store_align_unit #(
   parameter bit MISALIGN_SPLIT = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_data_i,
   input  logic [1:0]  req_size_i,
   output logic        mem_valid_o,
   input  logic        mem_ready_i,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [3:0]  mem_wstrb_o,
   output logic        done_o,
   output logic        err_o,
   output logic        busy_o
);

   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

   state_t      r_state;
   logic        r_spill;
   logic [31:0] r_b1_addr;
   logic [31:0] r_b1_wdata;
   logic [3:0]  r_b1_wstrb;
   logic        r_mem_valid;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic [3:0]  r_mem_wstrb;
   logic        r_done;
   logic        r_err;

   logic [1:0]  w_off;
   logic [2:0]  w_n;
   logic [3:0]  w_mask;
   logic [31:0] w_bmask;
   logic        w_spill;
   logic        w_reject;
   logic [63:0] w_data_sh;
   logic [7:0]  w_strb_sh;
   logic [31:0] w_base;

   // Decode byte count and lane masks from the request size; 11 is illegal.
   always_comb begin
      w_n     = 3'd4;
      w_mask  = 4'b1111;
      w_bmask = 32'hFFFF_FFFF;
      case (req_size_i)
         2'b00: begin w_n = 3'd1; w_mask = 4'b0001; w_bmask = 32'h0000_00FF; end
         2'b01: begin w_n = 3'd2; w_mask = 4'b0011; w_bmask = 32'h0000_FFFF; end
         default: ;
      endcase
   end

   // Shift data and strobes across a double-word window: the low word is
   // beat 0, the high word is the spill into beat 1. Unused data bytes are
   // masked first so lanes without a strobe always carry zero.
   assign w_off     = req_addr_i[1:0];
   assign w_spill   = ({2'b00, w_off} + {1'b0, w_n}) > 4'd4;
   assign w_reject  = (req_size_i == 2'b11) || (!MISALIGN_SPLIT && w_spill);
   assign w_data_sh = {32'h0, req_data_i & w_bmask} << {w_off, 3'b000};
   assign w_strb_sh = {4'h0, w_mask} << w_off;
   assign w_base    = {req_addr_i[31:2], 2'b00};

   // Control FSM with registered beat/response outputs; both beats are
   // computed at acceptance so later req_* changes cannot disturb them.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= IDLE;
         r_spill     <= 1'b0;
         r_b1_addr   <= '0;
         r_b1_wdata  <= '0;
         r_b1_wstrb  <= '0;
         r_mem_valid <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_wstrb <= '0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid_i) begin
                  if (w_reject) begin
                     r_state <= RESP;
                     r_done  <= 1'b1;
                     r_err   <= 1'b1;
                  end else begin
                     r_state     <= BEAT0;
                     r_spill     <= w_spill;
                     r_mem_valid <= 1'b1;
                     r_mem_addr  <= w_base;
                     r_mem_wdata <= w_data_sh[31:0];
                     r_mem_wstrb <= w_strb_sh[3:0];
                     // 32-bit add wraps 0xFFFFFFFC to 0x00000000
                     r_b1_addr   <= w_base + 32'd4;
                     r_b1_wdata  <= w_data_sh[63:32];
                     r_b1_wstrb  <= w_strb_sh[7:4];
                  end
               end
            end
            BEAT0: begin
               if (mem_ready_i) begin
                  if (r_spill) begin
                     r_state     <= BEAT1;
                     r_mem_addr  <= r_b1_addr;
                     r_mem_wdata <= r_b1_wdata;
                     r_mem_wstrb <= r_b1_wstrb;
                  end else begin
                     r_state     <= RESP;
                     r_mem_valid <= 1'b0;
                     r_mem_addr  <= '0;
                     r_mem_wdata <= '0;
                     r_mem_wstrb <= '0;
                     r_done      <= 1'b1;
                  end
               end
            end
            BEAT1: begin
               if (mem_ready_i) begin
                  r_state     <= RESP;
                  r_mem_valid <= 1'b0;
                  r_mem_addr  <= '0;
                  r_mem_wdata <= '0;
                  r_mem_wstrb <= '0;
                  r_done      <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
               r_err   <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready_o = (r_state == IDLE);
   assign busy_o      = (r_state != IDLE);
   assign mem_valid_o = r_mem_valid;
   assign mem_addr_o  = r_mem_addr;
   assign mem_wdata_o = r_mem_wdata;
   assign mem_wstrb_o = r_mem_wstrb;
   assign done_o      = r_done;
   assign err_o       = r_err;

endmodule

// File: tb/tb_store_align_unit.sv
// Bench for store_align_unit: table of single-request vectors with expected
// beats, plus hand sequences for stall, reject-without-split and mid-beat reset.
module tb_store_align_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic [1:0]  req_size;
   logic        mem_ready;

   logic        ready, mvalid, done, err, busy;
   logic [31:0] maddr, mwdata;
   logic [3:0]  mwstrb;
   logic        u1_ready, u1_mvalid, u1_done, u1_err, u1_busy;
   logic [31:0] u1_maddr, u1_mwdata;
   logic [3:0]  u1_mwstrb;

   int n_err = 0;
   int n_chk = 0;

   always #5 clk = ~clk;

   store_align_unit #(.MISALIGN_SPLIT(1'b1)) u0 (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(ready),
      .req_addr_i(req_addr), .req_data_i(req_data), .req_size_i(req_size),
      .mem_valid_o(mvalid), .mem_ready_i(mem_ready), .mem_addr_o(maddr),
      .mem_wdata_o(mwdata), .mem_wstrb_o(mwstrb), .done_o(done), .err_o(err),
      .busy_o(busy));

   store_align_unit #(.MISALIGN_SPLIT(1'b0)) u1 (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(u1_ready),
      .req_addr_i(req_addr), .req_data_i(req_data), .req_size_i(req_size),
      .mem_valid_o(u1_mvalid), .mem_ready_i(mem_ready), .mem_addr_o(u1_maddr),
      .mem_wdata_o(u1_mwdata), .mem_wstrb_o(u1_mwstrb), .done_o(u1_done),
      .err_o(u1_err), .busy_o(u1_busy));

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  size;
      bit          err;
      bit          spill;
      logic [31:0] a0;
      logic [3:0]  s0;
      logic [31:0] d0;
      logic [31:0] a1;
      logic [3:0]  s1;
      logic [31:0] d1;
   } vec_t;

   function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] data,
                               input logic [1:0] size, input bit e, input bit sp,
                               input logic [31:0] a0, input logic [3:0] s0,
                               input logic [31:0] d0, input logic [31:0] a1,
                               input logic [3:0] s1, input logic [31:0] d1);
      vec_t v;
      v.addr = addr; v.data = data; v.size = size; v.err = e; v.spill = sp;
      v.a0 = a0; v.s0 = s0; v.d0 = d0; v.a1 = a1; v.s1 = s1; v.d1 = d1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
      req_valid = 1'b1; req_addr = a; req_data = d; req_size = s;
   endtask

   // Scramble the request bus after acceptance; the held request must not change.
   task automatic drop_req();
      req_valid = 1'b0; req_addr = 32'hDEAD_0001; req_data = 32'h5A5A_5A5A; req_size = 2'b10;
   endtask

   // Called at a negedge with the unit idle and mem_ready=1.
   task automatic run_vec(input vec_t v, input int i);
      chk($sformatf("v%0d ready_idle", i), ready, 1);
      drive_req(v.addr, v.data, v.size);
      @(negedge clk);                       // cycle N+1
      drop_req();
      if (v.err) begin
         chk($sformatf("v%0d rej_valid", i), mvalid, 0);
         chk($sformatf("v%0d rej_done", i), done, 1);
         chk($sformatf("v%0d rej_err", i), err, 1);
      end else begin
         chk($sformatf("v%0d b0_valid", i), mvalid, 1);
         chk($sformatf("v%0d b0_busy", i), busy, 1);
         chk($sformatf("v%0d b0_ready", i), ready, 0);
         chk($sformatf("v%0d b0_addr", i), maddr, v.a0);
         chk($sformatf("v%0d b0_wstrb", i), mwstrb, v.s0);
         chk($sformatf("v%0d b0_wdata", i), mwdata, v.d0);
         chk($sformatf("v%0d b0_done", i), done, 0);
         if (v.spill) begin
            @(negedge clk);
            chk($sformatf("v%0d b1_valid", i), mvalid, 1);
            chk($sformatf("v%0d b1_addr", i), maddr, v.a1);
            chk($sformatf("v%0d b1_wstrb", i), mwstrb, v.s1);
            chk($sformatf("v%0d b1_wdata", i), mwdata, v.d1);
         end
         @(negedge clk);
         chk($sformatf("v%0d resp_done", i), done, 1);
         chk($sformatf("v%0d resp_err", i), err, 0);
         chk($sformatf("v%0d resp_valid", i), mvalid, 0);
         chk($sformatf("v%0d resp_addr", i), maddr, 0);
         chk($sformatf("v%0d resp_wstrb", i), mwstrb, 0);
         chk($sformatf("v%0d resp_wdata", i), mwdata, 0);
         chk($sformatf("v%0d resp_ready", i), ready, 0);
      end
      @(negedge clk);
      chk($sformatf("v%0d after_ready", i), ready, 1);
      chk($sformatf("v%0d after_done", i), done, 0);
   endtask

   vec_t vecs[8];

   initial begin
      int dcnt;
      vecs[0] = mk(32'h0000_1000, 32'hDEAD_BEEF, 2'b10, 0, 0, 32'h0000_1000, 4'b1111, 32'hDEAD_BEEF, 0, 0, 0);
      vecs[1] = mk(32'h0000_2003, 32'h0000_00A5, 2'b00, 0, 0, 32'h0000_2000, 4'b1000, 32'hA500_0000, 0, 0, 0);
      vecs[2] = mk(32'hFFFF_FFFF, 32'h0000_BEEF, 2'b01, 0, 1, 32'hFFFF_FFFC, 4'b1000, 32'hEF00_0000,
                   32'h0000_0000, 4'b0001, 32'h0000_00BE);
      vecs[3] = mk(32'h0000_3002, 32'h1122_3344, 2'b10, 0, 1, 32'h0000_3000, 4'b1100, 32'h3344_0000,
                   32'h0000_3004, 4'b0011, 32'h0000_1122);
      vecs[4] = mk(32'h0000_0001, 32'hFFFF_FF5A, 2'b00, 0, 0, 32'h0000_0000, 4'b0010, 32'h0000_5A00, 0, 0, 0);
      vecs[5] = mk(32'h0000_0002, 32'h1234_ABCD, 2'b01, 0, 0, 32'h0000_0000, 4'b1100, 32'hABCD_0000, 0, 0, 0);
      vecs[6] = mk(32'h0000_0010, 32'h1111_1111, 2'b11, 1, 0, 0, 0, 0, 0, 0, 0);
      vecs[7] = mk(32'h0000_5001, 32'h0000_BEEF, 2'b01, 0, 0, 32'h0000_5000, 4'b0110, 32'h00BE_EF00, 0, 0, 0);

      rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0; mem_ready = 1'b1;
      #7;
      chk("rst ready", ready, 1);
      chk("rst valid", mvalid, 0);
      chk("rst done", done, 0);
      chk("rst err", err, 0);
      chk("rst busy", busy, 0);
      chk("rst addr", maddr, 0);
      chk("rst wdata", mwdata, 0);
      chk("rst wstrb", mwstrb, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // Stalled BEAT0 for three cycles, then release into BEAT1.
      mem_ready = 1'b0;
      drive_req(32'h0000_3002, 32'h1122_3344, 2'b10);
      @(negedge clk);
      drop_req();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("stall%0d valid", k), mvalid, 1);
         chk($sformatf("stall%0d addr", k), maddr, 32'h0000_3000);
         chk($sformatf("stall%0d wstrb", k), mwstrb, 4'b1100);
         chk($sformatf("stall%0d wdata", k), mwdata, 32'h3344_0000);
         chk($sformatf("stall%0d done", k), done, 0);
         if (k == 2) mem_ready = 1'b1;
         @(negedge clk);
      end
      chk("stall b1 addr", maddr, 32'h0000_3004);
      chk("stall b1 wstrb", mwstrb, 4'b0011);
      chk("stall b1 wdata", mwdata, 32'h0000_1122);
      @(negedge clk);
      chk("stall done", done, 1);
      chk("stall err", err, 0);
      @(negedge clk);
      chk("stall ready", ready, 1);

      // MISALIGN_SPLIT=0 instance rejects a spilling half store.
      drive_req(32'h0000_0003, 32'h0000_BEEF, 2'b01);
      @(negedge clk);
      drop_req();
      chk("nosplit valid", u1_mvalid, 0);
      chk("nosplit done", u1_done, 1);
      chk("nosplit err", u1_err, 1);
      chk("split valid", mvalid, 1);
      @(negedge clk);
      chk("nosplit done_after", u1_done, 0);
      chk("nosplit ready", u1_ready, 1);
      @(negedge clk);
      @(negedge clk);
      chk("split idle", ready, 1);

      // Reset during a stalled BEAT1.
      mem_ready = 1'b0;
      drive_req(32'hFFFF_FFFF, 32'h0000_BEEF, 2'b01);
      @(negedge clk);
      drop_req();
      chk("rb b0 valid", mvalid, 1);
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      chk("rb b1 valid", mvalid, 1);
      chk("rb b1 addr", maddr, 32'h0000_0000);
      chk("rb b1 wstrb", mwstrb, 4'b0001);
      #2 rst_n = 1'b0;
      #1;
      chk("rb async valid", mvalid, 0);
      chk("rb async busy", busy, 0);
      chk("rb async ready", ready, 1);
      chk("rb async wstrb", mwstrb, 0);
      @(negedge clk);
      rst_n = 1'b1;
      mem_ready = 1'b1;
      dcnt = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      chk("rb no_done", dcnt, 0);
      chk("rb idle", busy, 0);
      run_vec(mk(32'h0000_0000, 32'h0000_0077, 2'b00, 0, 0, 32'h0000_0000, 4'b0001,
                 32'h0000_0077, 0, 0, 0), 99);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
